reg_bus_hub: RTL
================

# reg_bus_hub

Parametrised register-bus interconnect. It replaces the plain OR-combining of slave `ack`/`data_out`/`data_out_valid` lines between the address decoder and the register files (clock handler, UART, channel, colour, resolution). It broadcasts one transaction at a time to N slaves and waits for an acknowledge, with a timeout. It selects read data by the responding slave's index instead of OR-ing, and flags collisions (more than one ack) and timeouts as faults.

## Interface
- `N_SLAVES`, 5: number of attached register slaves (1..16).
- `ADDR_W`, 4: register address width.
- `DATA_W`, 4: register data width.
- `TIMEOUT`, 15: cycles waited for an ack before a timeout fault (1..255).

- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `m_valid`  in  1  request from the address decoder; held until `m_ack` or `m_fault`.
- `m_address`  in  ADDR_W  request address.
- `m_data`  in  DATA_W  request write data.
- `m_ack`  out  1  one-cycle pulse: transaction completed.
- `m_fault`  out  1  one-cycle pulse: timeout or collision.
- `m_rdata`  out  DATA_W  read data of the acknowledging slave.
- `m_rdata_valid`  out  1  one-cycle pulse with `m_ack` when the slave returned data.
- `s_valid`  out  1  broadcast request to all slaves.
- `s_address`  out  ADDR_W  registered copy of `m_address`.
- `s_data`  out  DATA_W  registered copy of `m_data`.
- `s_ack`  in  N_SLAVES  per-slave acknowledge.
- `s_rdata`  in  N_SLAVES*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- `s_rdata_valid`  in  N_SLAVES  per-slave read-data valid.
- `err_timeout`  out  1  sticky; cleared by reset only.
- `err_collision`  out  1  sticky; cleared by reset only.
- `last_slave`  out  4  index of the last acknowledging slave.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - `m_valid`=1: latch `m_address`/`m_data` into `s_address`/`s_data`, clear the wait counter, go to WAIT.
- WAIT:
  - `s_valid`=1 and the counter increments each cycle.
  - Exactly one `s_ack` bit set: capture its index into `last_slave`. Capture `s_rdata[idx]` into `m_rdata` and `s_rdata_valid[idx]` into the pending rdata flag. Go to DONE.
  - Two or more `s_ack` bits set: set `err_collision`. Take the lowest index as the winner for `last_slave`/`m_rdata`. Pulse `m_fault` and `m_ack` in DONE.
  - Counter reaches `TIMEOUT` with no ack: set `err_timeout`, go to DONE with fault pending and no ack. `m_rdata` is unchanged.
  - `m_valid` drops (abort): go to IDLE next cycle with no pulse.
- DONE:
  - Outputs `m_ack`, `m_rdata_valid` and `m_fault` as pending, for exactly one cycle. `s_valid`=0.
  - Next state is always IDLE. A request still high in DONE is not re-accepted; it is sampled again in IDLE (one bubble cycle).
- Arithmetic:
  - The wait counter is 8 bits and saturates at `TIMEOUT`.
  - `s_ack` bits at indices ≥ N_SLAVES do not exist. `s_ack` outside WAIT is ignored.
- Reset values: state IDLE; all pulses 0; `s_valid`=0; `s_address`, `s_data`, `m_rdata`, `last_slave` = 0; sticky errors 0.
- Reset asserted mid-transaction: back to IDLE on that edge with no ack/fault pulse.

## Timing
- Registered outputs only; no combinational path from the `m_*` inputs to the `m_*` outputs.
- `m_valid` sampled at edge T → `s_valid`=1 from T+1.
- Slave ack sampled at edge T+k (k≥1) → `m_ack` high for cycle T+k+1.
  - Minimum request-to-ack latency: 2 cycles.
  - Throughput: 1 transaction per 3 cycles.
- Timeout: `m_fault` pulses at T+TIMEOUT+1 when no ack arrives.
- `s_valid` deasserts in the cycle the ack is registered (DONE). Slaves must drop `s_ack` within one cycle.

## Configuration
- `REG_BUS_HUB_STATS_EN` defined:
  - Adds output `txn_count` (16 bits, increments on every `m_ack`) and output `fault_count` (8 bits, increments on every `m_fault`).
  - Both counters saturate at their maximum value and reset to 0.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Write, slave 2 acks one cycle after `s_valid`:
  - `m_ack` pulses 2 cycles after `m_valid` is sampled; `last_slave`=2; `m_fault`=0.
- Read, slave 4 returns `s_rdata`=4'hA with `s_rdata_valid`:
  - `m_rdata`=4'hA and `m_rdata_valid`=1 in the `m_ack` cycle.
  - All other slaves drive 4'hF; the result is unaffected.
- No slave acks, TIMEOUT=15:
  - `m_fault` pulses 16 cycles after the request; `err_timeout`=1; `m_ack` never pulses.
- Slaves 1 and 3 ack in the same cycle:
  - `m_ack` and `m_fault` pulse together; `last_slave`=1; `err_collision`=1 (sticky).
- Reset and abort:
  - `m_valid` drops in WAIT: IDLE with no pulses.
  - `rst`=0 asserted in WAIT: all outputs at reset values the next cycle.
- With `REG_BUS_HUB_STATS_EN`: 3 good transactions plus 1 timeout → `txn_count`=3, `fault_count`=1.

Source files
------------

// File: rtl/reg_bus_hub.sv
// Register-bus hub: broadcasts one request to N slaves, selects the acking slave's data.
// Optional REG_BUS_HUB_STATS_EN adds saturating transaction/fault counters.
module reg_bus_hub #(
  parameter int N_SLAVES = 5,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 4,
  parameter int TIMEOUT  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_valid,
  input  logic [ADDR_W-1:0]          m_address,
  input  logic [DATA_W-1:0]          m_data,
  output logic                       m_ack,
  output logic                       m_fault,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_rdata_valid,
  output logic                       s_valid,
  output logic [ADDR_W-1:0]          s_address,
  output logic [DATA_W-1:0]          s_data,
  input  logic [N_SLAVES-1:0]        s_ack,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_rdata_valid,
  output logic                       err_timeout,
  output logic                       err_collision,
  output logic [3:0]                 last_slave
`ifdef REG_BUS_HUB_STATS_EN
  ,
  output logic [15:0]                txn_count,
  output logic [7:0]                 fault_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [7:0] TO8 = 8'(TIMEOUT);
  localparam logic [N_SLAVES-1:0] ONE = 1;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic [3:0]          last_q, last_d;
  logic                sval_q, sval_d;
  logic                ack_q, ack_d;
  logic                flt_q, flt_d;
  logic                rv_q, rv_d;
  logic                errt_q, errt_d;
  logic                errc_q, errc_d;

  logic                ack_any;
  logic                ack_multi;
  logic [3:0]          win_idx;
  logic [DATA_W-1:0]   win_rdata;
  logic                win_rv;

  assign ack_any   = |s_ack;
  assign ack_multi = |(s_ack & (s_ack - ONE));

  // Lowest acking index wins; iterate downward so it is assigned last.
  always_comb begin
    win_idx   = '0;
    win_rdata = '0;
    win_rv    = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (s_ack[i]) begin
        win_idx   = 4'(i);
        win_rdata = s_rdata[i*DATA_W +: DATA_W];
        win_rv    = s_rdata_valid[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    last_d  = last_q;
    ack_d   = 1'b0;
    flt_d   = 1'b0;
    rv_d    = 1'b0;
    errt_d  = errt_q;
    errc_d  = errc_q;
    unique case (state_q)
      S_IDLE: begin
        if (m_valid) begin
          addr_d  = m_address;
          wdat_d  = m_data;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q == TO8) ? cnt_q : cnt_q + 8'd1;
        if (!m_valid) begin
          state_d = S_IDLE;
        end else if (ack_any) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
          rv_d    = win_rv;
          last_d  = win_idx;
          rdat_d  = win_rdata;
          if (ack_multi) begin
            flt_d  = 1'b1;
            errc_d = 1'b1;
          end
        end else if (cnt_d == TO8) begin
          state_d = S_DONE;
          flt_d   = 1'b1;
          errt_d  = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    sval_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      last_q  <= '0;
      sval_q  <= 1'b0;
      ack_q   <= 1'b0;
      flt_q   <= 1'b0;
      rv_q    <= 1'b0;
      errt_q  <= 1'b0;
      errc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      last_q  <= last_d;
      sval_q  <= sval_d;
      ack_q   <= ack_d;
      flt_q   <= flt_d;
      rv_q    <= rv_d;
      errt_q  <= errt_d;
      errc_q  <= errc_d;
    end
  end

  assign m_ack         = ack_q;
  assign m_fault       = flt_q;
  assign m_rdata       = rdat_q;
  assign m_rdata_valid = rv_q;
  assign s_valid       = sval_q;
  assign s_address     = addr_q;
  assign s_data        = wdat_q;
  assign err_timeout   = errt_q;
  assign err_collision = errc_q;
  assign last_slave    = last_q;

`ifdef REG_BUS_HUB_STATS_EN
  logic [15:0] txn_q;
  logic [7:0]  fcnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      txn_q  <= '0;
      fcnt_q <= '0;
    end else begin
      if (ack_q && txn_q != 16'hFFFF) txn_q <= txn_q + 16'd1;
      if (flt_q && fcnt_q != 8'hFF)   fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign txn_count   = txn_q;
  assign fault_count = fcnt_q;
`endif

endmodule
